// File: rtl/divide_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : divide_pkg                                                      |
// | Brief    : Shared constants and width helper for the divide_hz_bank tree.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package divide_pkg;

    localparam int C_DEFAULT_CLK_FREQ_HZ = 100_000_000;

    // Target output frequencies; 2.5 Hz is held in tenths of Hz to stay integral.
    localparam int C_TARGET_1000_HZ = 1000;
    localparam int C_TARGET_25_HZ   = 25;
    localparam int C_TARGET_2P5_DHZ = 25;

    // Bits needed to hold half-1, never less than one.
    function automatic int cnt_width(input int half);
        if (half > 1) begin
            return $clog2(half);
        end
        return 1;
    endfunction

endpackage : divide_pkg
`default_nettype wire

// File: rtl/divide_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : divide_stage                                                    |
// | Brief    : One square-wave divider; output toggles every HALF clk cycles.  |
// |            Optional tick pulse on each rising edge under DIVIDE_TICK_EN.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module divide_stage
    import divide_pkg::*;
#(
    parameter int HALF = 1
)
(
    input  logic clk,
    input  logic reset,
    output logic out
`ifdef DIVIDE_TICK_EN
    ,
    output logic tick
`endif
);

    localparam int                 c_cnt_w = cnt_width(HALF);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(HALF - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    generate
        if (HALF < 1) begin : g_bad_half
            $error("divide_stage: HALF must be at least 1");
        end
    endgenerate

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;
    logic               out_q;
    logic               out_d;
    logic               w_wrap;

    always_comb begin
        w_wrap = (cnt_q == c_last);
        cnt_d  = w_wrap ? '0 : cnt_q + c_one;
        out_d  = out_q ^ w_wrap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

`ifdef DIVIDE_TICK_EN
    logic tick_q;
    logic tick_d;

    // A wrap while low is exactly the edge on which out rises.
    always_comb begin
        tick_d = w_wrap & ~out_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`endif

endmodule : divide_stage
`default_nettype wire

// File: rtl/divide_hz_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : divide_hz_bank                                                  |
// | Brief    : Three independent dividers producing 1000 Hz, 25 Hz and 2.5 Hz  |
// |            square waves; DIVIDE_TICK_EN adds rising-edge tick outputs.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module divide_hz_bank
    import divide_pkg::*;
#(
    parameter int CLK_FREQ_HZ = C_DEFAULT_CLK_FREQ_HZ,
    parameter int HALF_1000   = CLK_FREQ_HZ / (2 * C_TARGET_1000_HZ),
    parameter int HALF_25     = CLK_FREQ_HZ / (2 * C_TARGET_25_HZ),
    parameter int HALF_2P5    = CLK_FREQ_HZ / ((2 * C_TARGET_2P5_DHZ) / 10)
)
(
    input  logic clk,
    input  logic reset,
    output logic clk_1000Hz,
    output logic clk_25Hz,
    output logic clk_2p5Hz
`ifdef DIVIDE_TICK_EN
    ,
    output logic tick_1000Hz,
    output logic tick_25Hz,
    output logic tick_2p5Hz
`endif
);

    // Stages share one reset so they leave reset on the same edge, phase-aligned.
    divide_stage #(.HALF(HALF_1000)) u_stage_1000 (
        .clk   (clk),
        .reset (reset),
`ifdef DIVIDE_TICK_EN
        .tick  (tick_1000Hz),
`endif
        .out   (clk_1000Hz)
    );

    divide_stage #(.HALF(HALF_25)) u_stage_25 (
        .clk   (clk),
        .reset (reset),
`ifdef DIVIDE_TICK_EN
        .tick  (tick_25Hz),
`endif
        .out   (clk_25Hz)
    );

    divide_stage #(.HALF(HALF_2P5)) u_stage_2p5 (
        .clk   (clk),
        .reset (reset),
`ifdef DIVIDE_TICK_EN
        .tick  (tick_2p5Hz),
`endif
        .out   (clk_2p5Hz)
    );

endmodule : divide_hz_bank
`default_nettype wire

// File: tb/tb_divide_hz_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_divide_hz_bank                                               |
// | Brief    : Scoreboard bench for divide_hz_bank with randomized reset pulses.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_divide_hz_bank;

    typedef struct {
        int         n;
        bit         in_reset;
        logic [5:0] clk_o;
        logic [5:0] tick_o;
    } exp_t;

    logic clk;
    logic reset;

    logic a_1000, a_25, a_2p5;
    logic b_1000, b_25, b_2p5;
    logic [5:0] w_clk;

    int    halves [6] = '{5, 200, 2000, 1, 2, 3};
    string names  [6] = '{"a_1000", "a_25", "a_2p5", "b_1000", "b_25", "b_2p5"};

    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_since = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIVIDE_TICK_EN
    logic ta_1000, ta_25, ta_2p5;
    logic tb_1000, tb_25, tb_2p5;
    logic [5:0] w_tick;
    assign w_tick = {tb_2p5, tb_25, tb_1000, ta_2p5, ta_25, ta_1000};
`endif

    assign w_clk = {b_2p5, b_25, b_1000, a_2p5, a_25, a_1000};

    divide_hz_bank #(.CLK_FREQ_HZ(10_000)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .clk_1000Hz  (a_1000),
        .clk_25Hz    (a_25),
`ifdef DIVIDE_TICK_EN
        .tick_1000Hz (ta_1000),
        .tick_25Hz   (ta_25),
        .tick_2p5Hz  (ta_2p5),
`endif
        .clk_2p5Hz   (a_2p5)
    );

    divide_hz_bank #(
        .CLK_FREQ_HZ (10_000),
        .HALF_1000   (1),
        .HALF_25     (2),
        .HALF_2P5    (3)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .clk_1000Hz  (b_1000),
        .clk_25Hz    (b_25),
`ifdef DIVIDE_TICK_EN
        .tick_1000Hz (tb_1000),
        .tick_25Hz   (tb_25),
        .tick_2p5Hz  (tb_2p5),
`endif
        .clk_2p5Hz   (b_2p5)
    );

    // n = rising clk edges seen with reset high since the last release.
    function automatic exp_t model(input int n, input bit in_reset);
        exp_t e;
        e.n        = n;
        e.in_reset = in_reset;
        e.clk_o    = '0;
        e.tick_o   = '0;
        for (int k = 0; k < 6; k++) begin
            if (!in_reset) begin
                e.clk_o[k]  = ((n / halves[k]) % 2) == 1;
                e.tick_o[k] = (n > 0) && ((n % (2 * halves[k])) == halves[k]);
            end
        end
        return e;
    endfunction

    task automatic run(input bit val, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            if (reset) n_since++;
            #1;
            reset = val;
            if (!val) n_since = 0;
            sb.push_back(model(n_since, !val));
        end
    endtask

    initial begin
        reset = 1'b1;
        #2 reset = 1'b0;
        run(1'b0, 3);
        run(1'b1, 4400);
        run(1'b1, 7);
        run(1'b0, 3);
        run(1'b1, 20);
        repeat (40) begin
            run(1'b1, $urandom_range(1, 60));
            run(1'b0, $urandom_range(1, 4));
        end
        run(1'b1, 30);
        repeat (3) @(posedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int k = 0; k < 6; k++) begin
                    n_tests++;
                    if (w_clk[k] !== e.clk_o[k]) begin
                        n_fail++;
                        $display("FAIL clk_%s n=%0d rst=%0b got=%0b expected=%0b",
                                 names[k], e.n, e.in_reset, w_clk[k], e.clk_o[k]);
                    end
`ifdef DIVIDE_TICK_EN
                    n_tests++;
                    if (w_tick[k] !== e.tick_o[k]) begin
                        n_fail++;
                        $display("FAIL tick_%s n=%0d rst=%0b got=%0b expected=%0b",
                                 names[k], e.n, e.in_reset, w_tick[k], e.tick_o[k]);
                    end
`endif
                end
            end
        end
    end

endmodule : tb_divide_hz_bank
`default_nettype wire
